// File: rtl/hex_entry.sv
// hex_entry
//   Button-driven 16-bit hex value editor. Four raw push-buttons are
//   synchronized and debounced. Their press edges move a digit cursor or
//   step the selected nibble up or down. A load strobe preloads the whole
//   value.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   btn_u      in   raw button: increment selected nibble (wraps F->0)
//   btn_d      in   raw button: decrement selected nibble (wraps 0->F)
//   btn_l      in   raw button: cursor toward MSB (wraps 3->0)
//   btn_r      in   raw button: cursor toward LSB (wraps 0->3)
//   load       in   one-cycle strobe: value <= load_val; discards button events
//   load_val   in   16-bit preload value
//   value      out  current 16-bit value; nibble k drives display digit k
//   digit_sel  out  selected nibble index, 0 = bits [3:0]
//   press      out  one-cycle pulse in the cycle after an accepted edit
module hex_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] value,
  output logic [1:0]  digit_sel,
  output logic        press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Button index: 0 = up, 1 = down, 2 = left, 3 = right
  logic [3:0]    raw;
  logic [3:0]    s1_q, s2_q;
  logic [3:0]    stable_q, stable_d;
  logic [3:0]    stable_dly_q;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    ev;

  logic [15:0]   value_q, value_d;
  logic [1:0]    sel_q, sel_d;
  logic          press_q, press_d;
  logic [3:0]    nib;

  assign raw = {btn_r, btn_l, btn_d, btn_u};

  // A level change is accepted only after s2 has differed from the
  // debounced level for DEBOUNCE_CYCLES consecutive edges. Any return to
  // the old level clears the count.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q         <= raw;
      s2_q         <= s1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Press edges only; release edges and held levels produce nothing.
  assign ev = stable_q & ~stable_dly_q;

  assign nib = value_q[{sel_q, 2'b00} +: 4];

  // One action per cycle in strict priority. Lower-priority events in the
  // same cycle are lost because ev lasts only one cycle.
  always_comb begin
    value_d = value_q;
    sel_d   = sel_q;
    press_d = 1'b0;
    if (load) begin
      value_d = load_val;
    end else if (ev[0]) begin
      value_d[{sel_q, 2'b00} +: 4] = nib + 4'd1;
      press_d = 1'b1;
    end else if (ev[1]) begin
      value_d[{sel_q, 2'b00} +: 4] = nib - 4'd1;
      press_d = 1'b1;
    end else if (ev[2]) begin
      sel_d   = sel_q + 2'd1;
      press_d = 1'b1;
    end else if (ev[3]) begin
      sel_d   = sel_q - 2'd1;
      press_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      sel_q   <= '0;
      press_q <= 1'b0;
    end else begin
      value_q <= value_d;
      sel_q   <= sel_d;
      press_q <= press_d;
    end
  end

  assign value     = value_q;
  assign digit_sel = sel_q;
  assign press     = press_q;

endmodule

// File: tb/tb_hex_entry.sv
module tb_hex_entry;

  logic        clk;
  logic        rst;
  logic        btn_u, btn_d, btn_l, btn_r;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] value;
  logic [1:0]  digit_sel;
  logic        press;

  hex_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_u     (btn_u),
    .btn_d     (btn_d),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .load      (load),
    .load_val  (load_val),
    .value     (value),
    .digit_sel (digit_sel),
    .press     (press)
  );

  typedef struct {
    logic [15:0] v;
    logic [1:0]  s;
    logic        p;
    int          c;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic        mon_en   = 1'b0;
  logic [15:0] prev_v   = '0;
  logic [1:0]  prev_s   = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any press pulse or output change is a DUT response and is
  // matched against the oldest expectation, including the edge it lands on.
  always @(negedge clk) begin
    if (mon_en && (press || value !== prev_v || digit_sel !== prev_s)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d value=%h sel=%0d press=%b", cyc, value, digit_sel, press);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (value !== e.v || digit_sel !== e.s || press !== e.p || cyc != e.c) begin
          failures++;
          $display("FAIL %s got value=%h sel=%0d press=%b cyc=%0d expected value=%h sel=%0d press=%b cyc=%0d",
                   e.name, value, digit_sel, press, cyc, e.v, e.s, e.p, e.c);
        end
      end
    end
    prev_v = value;
    prev_s = digit_sel;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_ev(input logic [15:0] v, input logic [1:0] s, input logic p,
                           input int c, input string name);
    exp_t e;
    e.v = v; e.s = s; e.p = p; e.c = c; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic set_btn(input int idx, input logic lvl);
    case (idx)
      0: btn_u = lvl;
      1: btn_d = lvl;
      2: btn_l = lvl;
      default: btn_r = lvl;
    endcase
  endtask

  // Clean press: first sample at cyc+1, edit lands on cyc+7 with DEBOUNCE_CYCLES=4.
  task automatic press_btn(input int idx, input logic [15:0] v, input logic [1:0] s,
                           input string name);
    expect_ev(v, s, 1'b1, cyc + 7, name);
    set_btn(idx, 1'b1);
    tick(10);
    set_btn(idx, 1'b0);
    tick(10);
  endtask

  initial begin
    rst = 1'b1;
    btn_u = 1'b0; btn_d = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
    load = 1'b0; load_val = '0;
    tick(3);
    rst = 1'b0;
    mon_en = 1'b1;

    // Idle after reset
    tick(20);
    checks++;
    if (value !== 16'h0000) begin failures++; $display("FAIL reset_value got %h expected 0000", value); end
    checks++;
    if (digit_sel !== 2'd0) begin failures++; $display("FAIL reset_sel got %0d expected 0", digit_sel); end
    checks++;
    if (press !== 1'b0) begin failures++; $display("FAIL reset_press got %b expected 0", press); end

    // Held button: one increment, no repeat
    press_btn(0, 16'h0001, 2'd0, "hold_u");

    // Bouncing button: three short highs then a hold -> single increment
    for (int k = 0; k < 3; k++) begin
      btn_u = 1'b1; tick(3);
      btn_u = 1'b0; tick(1);
    end
    expect_ev(16'h0002, 2'd0, 1'b1, cyc + 7, "bounce_u");
    btn_u = 1'b1; tick(12);
    btn_u = 1'b0; tick(10);

    // Cursor to nibble 1, load, then wrap tests
    press_btn(2, 16'h0002, 2'd1, "left_to_1");
    expect_ev(16'h00F0, 2'd1, 1'b0, cyc + 1, "load_00f0");
    load_val = 16'h00F0; load = 1'b1; tick(1);
    load = 1'b0; tick(3);
    press_btn(0, 16'h0000, 2'd1, "wrap_up");
    press_btn(1, 16'h00F0, 2'd1, "wrap_down");
    press_btn(3, 16'h00F0, 2'd0, "right_to_0");
    press_btn(3, 16'h00F0, 2'd3, "right_wrap_3");

    // U and L released from reset together: only U applies
    expect_ev(16'h0000, 2'd0, 1'b0, cyc, "reset_clear1");
    rst = 1'b1;
    btn_u = 1'b1; btn_l = 1'b1;
    tick(2);
    rst = 1'b0;
    expect_ev(16'h0001, 2'd0, 1'b1, cyc + 7, "simul_u_l");
    tick(12);
    btn_u = 1'b0; btn_l = 1'b0;
    tick(10);

    // Load on the event cycle wins and suppresses press
    expect_ev(16'hBEEF, 2'd0, 1'b0, cyc + 7, "load_beats_ev");
    btn_u = 1'b1;
    tick(6);
    load_val = 16'hBEEF; load = 1'b1; tick(1);
    load = 1'b0;
    tick(6);
    btn_u = 1'b0;
    tick(10);

    // Reset mid-debounce, button still held afterwards
    btn_d = 1'b1;
    tick(5);
    expect_ev(16'h0000, 2'd0, 1'b0, cyc, "reset_clear2");
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    expect_ev(16'h000F, 2'd0, 1'b1, cyc + 7, "held_through_reset");
    tick(12);
    btn_d = 1'b0;
    tick(10);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
